bus_arbiter4: RTL

//  Round-robin arbiter sharing one 32-bit sink among four requesters.

---
 rtl/arb_pkg.sv | 15 +
 rtl/multiplexor4_1.sv | 13 +
 rtl/bus_arbiter4.sv | 90 +++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared types, widths and round-robin pick helper for bus_arbiter4
package arb_pkg;
  localparam int N_REQ = 4;
  localparam int DATA_W = 32;
  typedef enum logic {IDLE, GRANT} state_t;
  // Returns {found, idx}: first requester after last, wrapping back to last itself.
  function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction
endpackage

// File: rtl/multiplexor4_1.sv
// multiplexor4_1: 4-to-1 data multiplexor driven by the arbiter's encoded owner
module multiplexor4_1 #(
  parameter int W = 32
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y
);
  assign y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
endmodule

// File: rtl/bus_arbiter4.sv
// bus_arbiter4: round-robin arbiter sharing one ready/valid sink among four sources.
// Define ARB_TIMEOUT_EN to revoke a grant after TIMEOUT stalled cycles.
module bus_arbiter4 import arb_pkg::*; #(
  parameter int MAX_BURST = 4
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_REQ-1:0]  i_req,
  input  logic [DATA_W-1:0] i_d0,
  input  logic [DATA_W-1:0] i_d1,
  input  logic [DATA_W-1:0] i_d2,
  input  logic [DATA_W-1:0] i_d3,
  input  logic              i_ready,
  output logic [N_REQ-1:0]  o_grant,
  output logic [1:0]        o_select,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_timeout
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  state_t state, state_d;
  logic [N_REQ-1:0] grant_d;
  logic [1:0] select_d, last, last_d, pick;
  logic [BW-1:0] beat_cnt, beat_d;
  logic found, beat, rel, take, to_hit;
  assign {found, pick} = rr_pick(i_req, last);
  assign o_valid = state == GRANT && i_req[o_select];
  assign beat = o_valid && i_ready;
  assign rel = (beat && beat_cnt == LAST_BEAT) || !i_req[o_select] || to_hit;
  assign take = state == IDLE || rel;
`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt, idle_d;
  logic stall;
  assign stall = o_valid && !i_ready;
  assign to_hit = stall && idle_cnt == TW'(TIMEOUT - 1);
  assign idle_d = (beat || take) ? '0 : idle_cnt + TW'(stall);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      idle_cnt  <= '0;
      o_timeout <= 1'b0;
    end else begin
      idle_cnt  <= idle_d;
      o_timeout <= to_hit;
    end
`else
  assign to_hit = 1'b0;
  assign o_timeout = 1'b0;
`endif
  always_comb begin
    state_d  = state;
    grant_d  = o_grant;
    select_d = o_select;
    last_d   = last;
    beat_d   = beat ? beat_cnt + 1'b1 : beat_cnt;
    if (take) begin
      state_d  = found ? GRANT : IDLE;
      grant_d  = found ? {{(N_REQ-1){1'b0}}, 1'b1} << pick : '0;
      select_d = found ? pick : o_select;
      last_d   = found ? pick : last;
      beat_d   = '0;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state    <= IDLE;
      o_grant  <= '0;
      o_select <= '0;
      last     <= 2'd3;
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      o_grant  <= grant_d;
      o_select <= select_d;
      last     <= last_d;
      beat_cnt <= beat_d;
    end
  multiplexor4_1 #(.W(DATA_W)) u_mux (
    .sel(o_select),
    .d0 (i_d0),
    .d1 (i_d1),
    .d2 (i_d2),
    .d3 (i_d3),
    .y  (o_data)
  );
endmodule
